// File: rtl/nexusv_pkg.sv
// Shared definitions for the nexusv performance monitor: FSM state encoding,
// CSR addresses served by the read port, and the status word layout.
package nexusv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } perf_state_t;

   localparam logic [11:0] CSR_MCYCLE      = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH     = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET    = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH   = 12'hB82;
   localparam logic [11:0] CSR_PERF_STATUS = 12'h7C0;
   localparam logic [11:0] CSR_PERF_RESULT = 12'h7C1;

   // Status word: {29'b0, state[1:0], done}
   function automatic logic [31:0] status_word(input perf_state_t st);
      return {29'b0, st, (st == ST_HALTED)};
   endfunction

endpackage

// File: rtl/nexusv_counter64.sv
// 64-bit free-running event counter with synchronous clear and silent wrap.
module nexusv_counter64 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        clr,
   output logic [63:0] count
);

   logic [63:0] cnt_q;

   // Clear wins over enable; all-ones rolls over to zero with no flag.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt_q <= 64'd0;
      end else if (en) begin
         cnt_q <= cnt_q + 64'd1;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/nexusv_perf_monitor.sv
// Benchmark performance monitor: counts cycles and retired instructions while
// a benchmark runs, stops when the halt PC retires with a non-zero a0, and
// exposes counters, status and result through a one-cycle-latency read port.
//
// Read handshake: rd_en is a one-cycle request with no back-pressure; the
// response (rd_valid, rd_data, rd_err) appears exactly one cycle later and
// reflects state sampled in the request cycle. A request may be issued every
// cycle. rd_data and rd_err are zero whenever rd_valid is low.
module nexusv_perf_monitor
   import nexusv_pkg::*;
#(
   parameter logic [31:0] HALT_PC          = 32'h0000_0008,
   parameter int unsigned HEARTBEAT_PERIOD = 10000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        clear,
   input  logic        retire_valid,
   input  logic [31:0] retire_pc,
   input  logic [31:0] a0_value,
   input  logic        rd_en,
   input  logic [11:0] rd_addr,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        rd_err,
   output logic        done,
   output logic        heartbeat
);

   localparam logic [31:0] HB_LAST = 32'(HEARTBEAT_PERIOD - 1);

   perf_state_t state_q, state_d;
   logic [63:0] mcycle, minstret;
   logic [31:0] mcycle_sh_q, minstret_sh_q;
   logic [31:0] result_q;
   logic [31:0] hb_cnt_q;
   logic        in_run, halt_hit, run_upd, hb_at_end;
   logic [31:0] mux_data;
   logic        mux_err;

   assign in_run    = (state_q == ST_RUN);
   assign halt_hit  = in_run && retire_valid && (retire_pc == HALT_PC) && (a0_value != 32'd0);
   assign run_upd   = in_run && !clear;
   assign hb_at_end = (hb_cnt_q == HB_LAST);
   assign heartbeat = in_run && hb_at_end;
   assign done      = (state_q == ST_HALTED);

   nexusv_counter64 u_mcycle (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (run_upd),
      .clr   (clear),
      .count (mcycle)
   );

   // The halting retire is not an instruction of the benchmark proper.
   nexusv_counter64 u_minstret (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (run_upd && retire_valid && !halt_hit),
      .clr   (clear),
      .count (minstret)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; clear overrides start and halt.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (!clear && start) state_d = ST_RUN;
         ST_RUN:    if (!clear && halt_hit) state_d = ST_HALTED;
         ST_HALTED: if (clear) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Result captures a0 on the halting retire and then holds.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         result_q <= 32'd0;
      end else if (run_upd && halt_hit) begin
         result_q <= a0_value;
      end
   end

   // Heartbeat counter advances only in RUN and restarts after each pulse.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         hb_cnt_q <= 32'd0;
      end else if (in_run) begin
         hb_cnt_q <= hb_at_end ? 32'd0 : hb_cnt_q + 32'd1;
      end
   end

   // Low-half reads snapshot the upper half so a following high read is coherent.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcycle_sh_q   <= 32'd0;
         minstret_sh_q <= 32'd0;
      end else if (rd_en) begin
         if (rd_addr == CSR_MCYCLE)   mcycle_sh_q   <= mcycle[63:32];
         if (rd_addr == CSR_MINSTRET) minstret_sh_q <= minstret[63:32];
      end
   end

   // Read address decode against pre-update values.
   always_comb begin
      mux_data = 32'd0;
      mux_err  = 1'b0;
      case (rd_addr)
         CSR_MCYCLE:      mux_data = mcycle[31:0];
         CSR_MCYCLEH:     mux_data = mcycle_sh_q;
         CSR_MINSTRET:    mux_data = minstret[31:0];
         CSR_MINSTRETH:   mux_data = minstret_sh_q;
         CSR_PERF_STATUS: mux_data = status_word(state_q);
         CSR_PERF_RESULT: mux_data = result_q;
         default:         mux_err  = 1'b1;
      endcase
   end

   // Response register: one cycle after the request, zeroed when idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= 32'd0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         rd_data  <= rd_en ? mux_data : 32'd0;
         rd_err   <= rd_en && mux_err;
      end
   end

endmodule

// File: tb/tb_nexusv_perf_monitor.sv
// Directed bench for nexusv_perf_monitor. Reads push their expected response
// into a queue; a monitor pops and compares on every rd_valid.
module tb_nexusv_perf_monitor;
  import nexusv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = 32'd0;
  logic [31:0] a0_value = 32'd0;
  logic        rd_en = 1'b0;
  logic [11:0] rd_addr = 12'd0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        done;
  logic        heartbeat;

  logic [31:0] exp_q[$];
  logic        err_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  nexusv_perf_monitor #(
    .HALT_PC          (32'h0000_0008),
    .HEARTBEAT_PERIOD (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clear        (clear),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .a0_value     (a0_value),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .done         (done),
    .heartbeat    (heartbeat)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    clear = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic issue_read(input logic [11:0] addr, input logic [31:0] exp_data,
                            input logic exp_err, input string name);
    rd_en   = 1'b1;
    rd_addr = addr;
    exp_q.push_back(exp_data);
    err_q.push_back(exp_err);
    name_q.push_back(name);
  endtask

  task automatic read_now(input logic [11:0] addr, input logic [31:0] exp_data,
                          input logic exp_err, input string name);
    issue_read(addr, exp_data, exp_err, name);
    tick();
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_rd_valid: got rd_data=%h rd_err=%b expected no response",
                   rd_data, rd_err);
        end else begin
          logic [31:0] ed;
          logic        ee;
          string       nm;
          ed = exp_q.pop_front();
          ee = err_q.pop_front();
          nm = name_q.pop_front();
          if (rd_data === ed && rd_err === ee) n_pass++;
          else $display("FAIL %s: got rd_data=%h rd_err=%b expected rd_data=%h rd_err=%b",
                        nm, rd_data, rd_err, ed, ee);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset
    tick();
    tick();
    check1("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    check1("reset_done", {31'b0, done}, 32'd0);
    check1("reset_heartbeat", {31'b0, heartbeat}, 32'd0);
    rst_n = 1'b1;
    tick();

    // idle reads, back to back
    issue_read(CSR_PERF_STATUS, 32'h0, 1'b0, "idle_status");  tick();
    issue_read(CSR_MCYCLE, 32'h0, 1'b0, "idle_mcycle");       tick();
    issue_read(12'h123, 32'h0, 1'b1, "unmapped_123");         tick();

    // benchmark: 20 retires, including pc=0x8 with a0=0, then the halt
    start = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      retire_valid = 1'b1;
      retire_pc    = 32'(4 * i);
      a0_value     = 32'd0;
      tick();
      if (i == 2) check1("no_halt_a0_zero_done", {31'b0, done}, 32'd0);
    end
    retire_pc = 32'h8;
    a0_value  = 32'h37;
    tick();
    retire_valid = 1'b0;
    a0_value     = 32'd0;
    check1("halt_done", {31'b0, done}, 32'd1);
    read_now(CSR_PERF_STATUS, 32'h5, 1'b0, "halted_status");
    read_now(CSR_MINSTRET, 32'd20, 1'b0, "halt_minstret");
    read_now(CSR_MCYCLE, 32'd21, 1'b0, "halt_mcycle");
    read_now(CSR_MCYCLEH, 32'd0, 1'b0, "halt_mcycleh");
    read_now(CSR_MINSTRETH, 32'd0, 1'b0, "halt_minstreth");
    read_now(CSR_PERF_RESULT, 32'h37, 1'b0, "halt_result");

    // start ignored in HALTED, counters frozen
    start = 1'b1;
    tick();
    read_now(CSR_PERF_STATUS, 32'h5, 1'b0, "halted_start_ignored");
    read_now(CSR_MCYCLE, 32'd21, 1'b0, "halted_mcycle_frozen");

    // clear from HALTED goes to IDLE with everything zero
    clear = 1'b1;
    tick();
    read_now(CSR_PERF_STATUS, 32'h0, 1'b0, "clear_status_idle");
    read_now(CSR_MCYCLE, 32'd0, 1'b0, "clear_mcycle");
    read_now(CSR_MINSTRET, 32'd0, 1'b0, "clear_minstret");
    read_now(CSR_PERF_RESULT, 32'd0, 1'b0, "clear_result");

    // heartbeat with period 4 over 12 RUN cycles
    start = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      check1($sformatf("heartbeat_cycle%0d", k), {31'b0, heartbeat},
             {31'b0, (k % 4) == 0});
      tick();
    end
    read_now(CSR_MCYCLE, 32'd12, 1'b0, "run12_mcycle");

    // clear together with a halt condition: stays RUN, counters zero
    clear        = 1'b1;
    retire_valid = 1'b1;
    retire_pc    = 32'h8;
    a0_value     = 32'h5;
    tick();
    retire_valid = 1'b0;
    a0_value     = 32'd0;
    read_now(CSR_MCYCLE, 32'd0, 1'b0, "clear_halt_mcycle");
    read_now(CSR_PERF_STATUS, 32'h2, 1'b0, "clear_halt_status_run");
    read_now(CSR_PERF_RESULT, 32'd0, 1'b0, "clear_halt_result");
    read_now(CSR_MINSTRET, 32'd0, 1'b0, "clear_halt_minstret");

    // reset mid-RUN with a read in flight: no response, status back to 0
    rd_en   = 1'b1;
    rd_addr = CSR_MCYCLE;
    rst_n   = 1'b0;
    tick();
    check1("reset_drops_read", {31'b0, rd_valid}, 32'd0);
    rst_n = 1'b1;
    read_now(CSR_PERF_STATUS, 32'h0, 1'b0, "reset_mid_run_status");

    // shadow coherency across a low-half carry
    force dut.u_mcycle.cnt_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.u_mcycle.cnt_q;
    issue_read(CSR_MCYCLE, 32'hFFFF_FFFF, 1'b0, "shadow_low");
    start = 1'b1;
    tick();
    tick();
    tick();
    read_now(CSR_MCYCLEH, 32'd0, 1'b0, "shadow_high_old");
    read_now(CSR_MCYCLE, 32'd2, 1'b0, "shadow_low_after_carry");
    read_now(CSR_MCYCLEH, 32'd1, 1'b0, "shadow_high_new");

    // 64-bit wrap to zero
    force dut.u_mcycle.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.u_mcycle.cnt_q;
    tick();
    read_now(CSR_MCYCLE, 32'd0, 1'b0, "wrap_low");
    read_now(CSR_MCYCLEH, 32'd0, 1'b0, "wrap_high");

    // drain and report
    tick();
    tick();
    tick();
    check1("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nexusv_perf_monitor.md
NEXUSV_PERF_MONITOR -- requirements
Module: nexusv_perf_monitor

Interface
REQ-001 Parameter HALT_PC, default 32'h0000_0008: retire address that signals benchmark completion.
REQ-002 Parameter HEARTBEAT_PERIOD, default 10000: RUN cycles between heartbeat pulses.
REQ-003 clk  input  1  core clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  single-cycle pulse; begins measurement.
REQ-006 clear  input  1  single-cycle pulse; zeroes counters.
REQ-007 retire_valid  input  1  one instruction retires this cycle.
REQ-008 retire_pc  input  32  PC of the retiring instruction.
REQ-009 a0_value  input  32  current register x10 value.
REQ-010 rd_en  input  1  read request, one cycle.
REQ-011 rd_addr  input  12  CSR address of the read.
REQ-012 rd_valid  output  1  read data valid, one-cycle pulse.
REQ-013 rd_data  output  32  read data, qualified by rd_valid.
REQ-014 rd_err  output  1  unmapped address, qualified by rd_valid.
REQ-015 done  output  1  high while in HALTED.
REQ-016 heartbeat  output  1  one-cycle progress pulse.

Function
REQ-017 FSM states: IDLE, RUN, HALTED; IDLE->RUN on start; start ignored in RUN/HALTED.
REQ-018 RUN: 64-bit mcycle +1 every cycle; 64-bit minstret +1 per cycle with retire_valid=1.
REQ-019 RUN->HALTED when retire_valid=1, retire_pc==HALT_PC, a0_value!=0; that retire not counted in minstret; mcycle counts the halting cycle.
REQ-020 On the halt transition result register latches a0_value; HALTED freezes mcycle, minstret, result.
REQ-021 clear: zero mcycle, minstret, result, heartbeat counter; RUN stays RUN, HALTED->IDLE, IDLE stays IDLE.
REQ-022 clear has priority over start, increments and halt in the same cycle (clear+halt in RUN -> RUN, counters 0).
REQ-023 Counters wrap 2^64-1 -> 0 silently; no status flag.
REQ-024 heartbeat counter runs in RUN only; reaching HEARTBEAT_PERIOD-1 -> heartbeat=1 one cycle, counter -> 0.
REQ-025 Read map: 0xB00 mcycle[31:0], 0xB80 mcycle[63:32] shadow, 0xB02 minstret[31:0], 0xB82 minstret[63:32] shadow, 0x7C0 status {29'b0, state[1:0] (IDLE=0, RUN=1, HALTED=2), done}, 0x7C1 result.
REQ-026 Read latency 1: rd_en in cycle N -> rd_valid, rd_data, rd_err in cycle N+1; values sampled at cycle N, before that cycle's update.
REQ-027 Reading 0xB00/0xB02 also latches that counter's upper 32 bits into its shadow; 0xB80/0xB82 return the shadow (coherent 64-bit pair).
REQ-028 Unmapped address: rd_data=0, rd_err=1; rd_err=0 on mapped reads and when rd_valid=0.
REQ-029 Back-to-back rd_en every cycle is supported at full throughput.

Reset
REQ-030 rst_n=0 at an edge: state IDLE, counters, shadows, result, heartbeat counter 0; rd_valid, rd_err, done, heartbeat, rd_data 0.
REQ-031 Reset mid-RUN or during an outstanding read discards all; no rd_valid in the cycle after reset.

Structure
REQ-032 Shared package nexusv_pkg holds state encoding and CSR address constants (CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH, CSR_PERF_STATUS, CSR_PERF_RESULT).
REQ-033 One sub-module, nexusv_counter64 (enable, clear, 64-bit wrap), instantiated twice; FSM and read mux in top level.

Verification
REQ-034 start, 20 cycles with retire_valid=1 (pc 0x0..0x4C), then pc=0x8 with a0=0x37 -> done=1, minstret=20, mcycle=21, result=0x37.
REQ-035 In RUN, retire pc=0x8 with a0=0 -> no halt, minstret increments, done=0.
REQ-036 Preload via run: mcycle low=0xFFFF_FFFF; read 0xB00 then, 3 cycles later, 0xB80 -> rd_data 0xFFFF_FFFF then old upper half (0), not 1.
REQ-037 Read 0x123 -> next cycle rd_valid=1, rd_err=1, rd_data=0.
REQ-038 HEARTBEAT_PERIOD=4, run 12 cycles -> heartbeat pulses at RUN cycles 4, 8, 12 only.
REQ-039 clear with halt condition same cycle -> state RUN, counters 0; rst_n=0 mid-RUN -> status read returns 0.
